// File: rtl/tow_round_ctrl_pkg.sv
// tow_pkg: shared types and helpers for the tug-of-war round controller.
//   state_t        - controller FSM states
//   LFSR_SEED      - reset value of the 16-bit round-delay LFSR
//   LFSR_TAPS      - Fibonacci tap mask (taps 16,14,13,11)
//   onehot_to_idx  - index of the highest set bit of an 8-bit vector
//   popcount_gt1   - true when more than one bit of an 8-bit vector is set
package tow_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT,
    GO,
    RESULT,
    DONE
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [2:0] onehot_to_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // v & (v-1) clears the lowest set bit; anything left means two or more.
  function automatic logic popcount_gt1(input logic [7:0] v);
    return |(v & (v - 8'd1));
  endfunction

endpackage

// File: rtl/tow_round_ctrl_if.sv
// tow_round_ctrl_if: button/request inputs and game-state outputs of the
// round controller.
//   master modport - button synchronizer / host side (drives btn, start)
//   slave modport  - tow_round_ctrl side (drives all display-facing outputs)
//   btn[NUM_PLAYERS]            synchronized button levels, 1 = pressed
//   start                       single-cycle match begin/restart request
//   go_led                      high while in GO
//   round_valid / tie / false_start  one-cycle event pulses
//   round_winner[NUM_PLAYERS]   one-hot last round winner
//   scores[NUM_PLAYERS*SCORE_W] packed per-player scores
//   match_over / match_winner   match result
interface tow_round_ctrl_if #(
  parameter int unsigned NUM_PLAYERS = 4,
  parameter int unsigned SCORE_W     = 4
);
  localparam int unsigned IW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;

  logic [NUM_PLAYERS-1:0]         btn;
  logic                           start;
  logic                           go_led;
  logic                           round_valid;
  logic [NUM_PLAYERS-1:0]         round_winner;
  logic                           tie;
  logic                           false_start;
  logic [NUM_PLAYERS*SCORE_W-1:0] scores;
  logic                           match_over;
  logic [IW-1:0]                  match_winner;

  modport master (
    output btn, start,
    input  go_led, round_valid, round_winner, tie, false_start,
           scores, match_over, match_winner
  );

  modport slave (
    input  btn, start,
    output go_led, round_valid, round_winner, tie, false_start,
           scores, match_over, match_winner
  );
endinterface

// File: rtl/tow_round_ctrl_lfsr.sv
// tow_lfsr16: 16-bit Fibonacci LFSR (taps 16,14,13,11), advancing every clock.
//   clk     system clock
//   rst     synchronous active-high reset, loads LFSR_SEED
//   o_state current LFSR contents
module tow_lfsr16
  import tow_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] o_state
);

  logic [15:0] r_state;

  always_ff @(posedge clk) begin
    if (rst) r_state <= LFSR_SEED;
    else     r_state <= {r_state[14:0], ^(r_state & LFSR_TAPS)};
  end

  assign o_state = r_state;

endmodule

// File: rtl/tow_round_ctrl.sv
// tow_round_ctrl: round/match controller for the reaction tug-of-war game.
// Arms a round, waits a pseudo-random number of ticks, raises GO and awards
// the round to the first single press; detects ties and false starts, keeps
// per-player scores and ends the match when a score reaches WIN_SCORE.
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  tow_round_ctrl_if.slave (btn/start in, display outputs out)
// Optional feature macro: FALSE_START_PENALTY_EN -- when defined, each player
// pressing during WAIT loses one point (saturating at 0).
module tow_round_ctrl
  import tow_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS = 4,
  parameter int unsigned SCORE_W     = 4,
  parameter int unsigned WIN_SCORE   = 9,
  parameter int unsigned DELAY_W     = 6,
  parameter int unsigned TICK_DIV    = 256
) (
  input logic             clk,
  input logic             rst,
  tow_round_ctrl_if.slave bus
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned IW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;

  // Tick prescaler
  logic [PW-1:0] r_presc;
  logic          w_tick;

  assign w_tick = (r_presc == PW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || w_tick) r_presc <= '0;
    else               r_presc <= r_presc + PW'(1);
  end

  // Random delay source
  logic [15:0] w_lfsr;
  logic        w_unused_lfsr;

  tow_lfsr16 u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .o_state (w_lfsr)
  );

  assign w_unused_lfsr = ^w_lfsr[15:DELAY_W-1];

  // Controller state and registered outputs
  state_t                                r_state;
  logic [DELAY_W-1:0]                    r_wait_cnt;
  logic [NUM_PLAYERS-1:0][SCORE_W-1:0]   r_scores;
  logic [NUM_PLAYERS-1:0]                r_round_winner;
  logic                                  r_go_led;
  logic                                  r_round_valid;
  logic                                  r_tie;
  logic                                  r_false_start;
  logic                                  r_match_over;
  logic [IW-1:0]                         r_match_winner;

  // Press/score decoding
  logic [7:0]    w_btn8;
  logic [7:0]    w_win8;
  logic          w_any_btn;
  logic          w_btn_multi;
  logic [IW-1:0] w_btn_idx;
  logic [IW-1:0] w_win_idx;

  always_comb begin
    w_btn8 = '0;
    w_btn8[NUM_PLAYERS-1:0] = bus.btn;
    w_win8 = '0;
    for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
      w_win8[i] = (r_scores[i] == SCORE_W'(WIN_SCORE));
    end
  end

  assign w_any_btn   = |bus.btn;
  assign w_btn_multi = popcount_gt1(w_btn8);
  assign w_btn_idx   = IW'(onehot_to_idx(w_btn8));
  assign w_win_idx   = IW'(onehot_to_idx(w_win8));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_wait_cnt     <= '0;
      r_scores       <= '0;
      r_round_winner <= '0;
      r_go_led       <= 1'b0;
      r_round_valid  <= 1'b0;
      r_tie          <= 1'b0;
      r_false_start  <= 1'b0;
      r_match_over   <= 1'b0;
      r_match_winner <= '0;
    end else begin
      r_round_valid <= 1'b0;
      r_tie         <= 1'b0;
      r_false_start <= 1'b0;

      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_scores <= '0;
            r_state  <= ARM;
          end
        end

        ARM: begin
          if (!w_any_btn) begin
            r_wait_cnt <= {1'b1, w_lfsr[DELAY_W-2:0]};
            r_state    <= WAIT;
          end
        end

        WAIT: begin
          // A press beats a coinciding expiry.
          if (w_any_btn) begin
            r_false_start <= 1'b1;
            r_state       <= ARM;
`ifdef FALSE_START_PENALTY_EN
            for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
              if (bus.btn[i] && (r_scores[i] != '0))
                r_scores[i] <= r_scores[i] - SCORE_W'(1);
            end
`endif
          end else if (w_tick) begin
            r_wait_cnt <= r_wait_cnt - DELAY_W'(1);
            if (r_wait_cnt == DELAY_W'(1)) begin
              r_go_led <= 1'b1;
              r_state  <= GO;
            end
          end
        end

        GO: begin
          // The press is decoded on the edge into RESULT, so the registered
          // round_valid/tie and the updated score are visible during RESULT,
          // one cycle after the press -- same timing as decoding a captured
          // sample inside RESULT with combinational outputs.
          if (w_any_btn) begin
            r_go_led <= 1'b0;
            r_state  <= RESULT;
            if (w_btn_multi) begin
              r_tie <= 1'b1;
            end else begin
              r_round_valid       <= 1'b1;
              r_round_winner      <= bus.btn;
              r_scores[w_btn_idx] <= r_scores[w_btn_idx] + SCORE_W'(1);
            end
          end
        end

        RESULT: begin
          if (|w_win8) begin
            r_match_over   <= 1'b1;
            r_match_winner <= w_win_idx;
            r_state        <= DONE;
          end else begin
            r_state <= ARM;
          end
        end

        DONE: begin
          if (bus.start) begin
            r_scores       <= '0;
            r_round_winner <= '0;
            r_match_over   <= 1'b0;
            r_match_winner <= '0;
            r_state        <= ARM;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.go_led       = r_go_led;
  assign bus.round_valid  = r_round_valid;
  assign bus.round_winner = r_round_winner;
  assign bus.tie          = r_tie;
  assign bus.false_start  = r_false_start;
  assign bus.scores       = r_scores;
  assign bus.match_over   = r_match_over;
  assign bus.match_winner = r_match_winner;

endmodule

// File: doc/tow_round_ctrl.md
Name: tow_round_ctrl

Overview:
- Parametrised round/match controller for the reaction tug-of-war game, generalising the two-button latch, scorer and main-controller chain to NUM_PLAYERS.
- Arms a round, waits a pseudo-random delay, raises GO, and takes the first press as the round winner.
- Detects ties and false starts and keeps a per-player score. Declares a match winner when any score reaches WIN_SCORE.
- Sits between the button synchronizers and the LED/VGA display logic.

Parameters:
- NUM_PLAYERS, 4, number of players (2..8).
- SCORE_W, 4, width of each score counter.
- WIN_SCORE, 9, score that ends the match; must be < 2**SCORE_W.
- DELAY_W, 6, width of the random wait in ticks (2..16).
- TICK_DIV, 256, clocks per tick (≥2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- btn  in  NUM_PLAYERS  synchronized button levels, 1 = pressed.
- start  in  1  single-cycle request to begin or restart a match.
- go_led  out  1  high while in GO.
- round_valid  out  1  one-cycle pulse when a round is decided with a single winner.
- round_winner  out  NUM_PLAYERS  one-hot winner, held until the next round_valid.
- tie  out  1  one-cycle pulse when ≥2 players press in the same first cycle.
- false_start  out  1  one-cycle pulse when a press occurs during WAIT.
- scores  out  NUM_PLAYERS*SCORE_W  packed scores, player i in bits [i*SCORE_W +: SCORE_W].
- match_over  out  1  high in DONE.
- match_winner  out  $clog2(NUM_PLAYERS)  index of the match winner, valid while match_over is high.

Behaviour:
- Reset (synchronous, any state): FSM goes to IDLE; every output is 0; prescaler = 0; LFSR = 16'hACE1.
- Prescaler: free-running 0..TICK_DIV-1. A tick is the cycle in which the count equals TICK_DIV-1.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every clk.
- IDLE: wait for start → ARM. On start, scores are cleared.
- ARM: wait until btn == 0 for one cycle → WAIT. On entry to WAIT, load wait_cnt = {1'b1, lfsr[DELAY_W-2:0]}, giving 2^(DELAY_W-1)..2^DELAY_W-1 ticks.
- WAIT: wait_cnt decrements on each tick.
  - Any btn bit high → false_start pulse, go to ARM.
  - Otherwise, wait_cnt reaching 0 → GO.
  - If a press and wait_cnt expiry occur in the same cycle, the press wins (false start).
- GO: go_led = 1. No timeout. First cycle with btn != 0 → RESULT.
- RESULT (1 cycle), evaluating the btn sample captured on the transition into RESULT:
  - Exactly one bit set → round_valid pulse, round_winner updated, that player's score incremented.
  - More than one bit set → tie pulse, no score change.
- Decision latency: round_valid or tie is asserted 1 cycle after the first press is seen in GO.
- After RESULT: if any score == WIN_SCORE → DONE; otherwise → ARM.
  - Scores cannot exceed WIN_SCORE, so there is no wrap-around.
- DONE: match_over = 1. match_winner = index of the player at WIN_SCORE. Scores and round_winner are held. start → clear scores and round_winner, go to ARM.
- start outside IDLE and DONE is ignored.

Optional Feature:
- FALSE_START_PENALTY_EN
- Defined: on a false start, every player whose btn bit is high loses 1 point, saturating at 0. The false_start pulse and the return to ARM are unchanged.
- Undefined: a false start only pulses false_start and re-arms; scores are untouched.

Decomposition:
- Package tow_pkg holds:
  - the state enum: IDLE, ARM, WAIT, GO, RESULT, DONE;
  - LFSR_SEED = 16'hACE1;
  - the LFSR tap mask;
  - the onehot-to-index and popcount-greater-than-1 helper functions.
- One sub-module is natural: tow_lfsr16 (clk, rst, state out).
- The prescaler and score counters stay inline.

Test Plan:
(All cases use NUM_PLAYERS=4, TICK_DIV=4, DELAY_W=4, WIN_SCORE=3 unless stated.)
- Reset mid-GO: assert rst in GO → next cycle IDLE, go_led=0, scores=0, all pulse outputs 0, LFSR=16'hACE1.
- Single winner: start, wait for go_led, press btn=4'b0100 → round_valid 1 cycle later, round_winner=4'b0100, scores[8+:4]=1. Release → ARM.
- Tie: in GO, btn=4'b1001 in the same cycle → tie pulse, round_valid=0, scores unchanged.
- False start: btn[1] pressed during WAIT → false_start pulse, state ARM, go_led never rises.
  - With FALSE_START_PENALTY_EN and player 1 at score 2 → score 1.
  - At score 0 → stays 0.
- Match end: player 3 wins three rounds → match_over=1, match_winner=3. A start issued while the match is still in progress (before match_over) is ignored. A start after match_over → scores=0, state ARM.
- Wait bounds: over 50 rounds, GO rises between 8 and 15 ticks (32..60 clk) after WAIT entry. A press coinciding with wait_cnt expiry yields false_start.
